// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data SRAM port arbiter:
//   - resp_e      : owner of the read response returning one cycle after a grant
//   - ARB_*       : default widths and streak limit used by the arbiter modules
//   - STREAK_W    : width of the data-grant streak counter (limit range 1..15)
// Optional feature macro used by the top: MEM_ARB_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_e;

    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_MAX_STREAK = 4;
    localparam int STREAK_W       = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
// Grant selection between the instruction and data requesters, plus the
// streak counter that bounds how long data traffic may keep instruction fetch
// waiting. Grants are purely combinational; only the streak is registered.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-low reset (0 = reset); blocks all grants
//   inst_req  in   instruction request pending
//   data_req  in   data request pending
//   gnt_inst  out  instruction request wins this cycle
//   gnt_data  out  data request wins this cycle (never together with gnt_inst)
// -----------------------------------------------------------------------------
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = ARB_MAX_STREAK
) (
    input  logic clk,
    input  logic reset,
    input  logic inst_req,
    input  logic data_req,
    output logic gnt_inst,
    output logic gnt_data
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                streak_full;

    // Once data has won STREAK_MAX times in a row over a waiting fetch,
    // the fetch gets the next slot.
    assign streak_full = (streak_q == STREAK_MAX);

    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (reset) begin
            if (data_req && !(inst_req && streak_full)) begin
                gnt_data = 1'b1;
            end else if (inst_req) begin
                gnt_inst = 1'b1;
            end
        end
    end

    // The streak only measures how long a *waiting* fetch has been passed
    // over, so it restarts whenever fetch is idle or gets served.
    always_comb begin
        streak_d = streak_q;
        if (gnt_inst || !inst_req) begin
            streak_d = '0;
        end else if (gnt_data && !streak_full) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule : mem_arb_prio

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one synchronous, write-first, single-port SRAM between the
// instruction-fetch requester and the memory-stage data requester. At most
// one request is granted per cycle; the SRAM port is driven combinationally
// from the winner, and the response returning one cycle later is routed back
// to whichever requester owned the grant. A new grant may be issued in the
// same cycle a response returns, so throughput is one access per cycle.
//
// Ports:
//   clk, reset                  clock; synchronous active-low reset (0 = reset)
//   inst_req/inst_addr          instruction read request (held until addr_ok)
//   inst_addr_ok                instruction request granted this cycle
//   inst_data_ok/inst_rdata     instruction read data, one cycle after grant
//   data_req/data_wr/data_wstrb data request: store when data_wr=1
//   data_addr/data_wdata        data address and store data
//   data_addr_ok                data request granted this cycle
//   data_data_ok/data_rdata     load data / store complete, one cycle after grant
//   sram_en/sram_we/sram_addr/sram_wdata  SRAM request port
//   sram_rdata                  SRAM read data, valid one cycle after sram_en
//   perf_inst_stall, perf_data_grant      only with MEM_ARB_PERF_CNT_EN defined
//
// Optional feature: define MEM_ARB_PERF_CNT_EN to add two 32-bit wrapping
// performance counters (fetch stall cycles, data grants).
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = ARB_ADDR_W,
    parameter int DATA_W          = ARB_DATA_W,
    parameter int MAX_DATA_STREAK = ARB_MAX_STREAK
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]         perf_inst_stall,
    output logic [31:0]         perf_data_grant,
`endif
    input  logic [DATA_W-1:0]   sram_rdata
);

    logic  gnt_inst;
    logic  gnt_data;
    resp_e resp_q;
    resp_e resp_d;

    mem_arb_prio #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .inst_req (inst_req),
        .data_req (data_req),
        .gnt_inst (gnt_inst),
        .gnt_data (gnt_data)
    );

    assign inst_addr_ok = gnt_inst;
    assign data_addr_ok = gnt_data;

    // SRAM request port follows the winner; idle port is driven to all zeros
    // so nothing downstream sees stale addresses or data.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (gnt_inst) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (gnt_data) begin
            sram_en    = 1'b1;
            sram_we    = data_wr ? data_wstrb : '0;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end
    end

    // Owner of the response that the SRAM will present next cycle.
    always_comb begin
        resp_d = RESP_NONE;
        if (gnt_inst) begin
            resp_d = RESP_INST;
        end else if (gnt_data) begin
            resp_d = RESP_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_q <= RESP_NONE;
        end else begin
            resp_q <= resp_d;
        end
    end

    // Gated with reset so a response already in flight when reset lands is
    // suppressed immediately instead of leaking out during the reset cycle.
    assign inst_data_ok = reset && (resp_q == RESP_INST);
    assign data_data_ok = reset && (resp_q == RESP_DATA);

    // Read data needs no muxing: only one owner can be outstanding.
    assign inst_rdata = sram_rdata;
    assign data_rdata = sram_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_inst_stall_q;
    logic [31:0] perf_inst_stall_d;
    logic [31:0] perf_data_grant_q;
    logic [31:0] perf_data_grant_d;

    always_comb begin
        perf_inst_stall_d = perf_inst_stall_q;
        perf_data_grant_d = perf_data_grant_q;
        if (inst_req && !gnt_inst) begin
            perf_inst_stall_d = perf_inst_stall_q + 32'd1;
        end
        if (gnt_data) begin
            perf_data_grant_d = perf_data_grant_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_inst_stall_q <= '0;
            perf_data_grant_q <= '0;
        end else begin
            perf_inst_stall_q <= perf_inst_stall_d;
            perf_data_grant_q <= perf_data_grant_d;
        end
    end

    assign perf_inst_stall = perf_inst_stall_q;
    assign perf_data_grant = perf_data_grant_q;
`endif

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Each stimulus cycle pushes the
// expected SRAM-port/grant state for that cycle and, for a grant, the
// expected response one cycle later. A negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int GN = 0;  // no grant
    localparam int GI = 1;  // instruction grant
    localparam int GD = 2;  // data grant

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_inst_stall;
    logic [31:0] perf_data_grant;
`endif

    mem_port_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
`ifdef MEM_ARB_PERF_CNT_EN
        .perf_inst_stall (perf_inst_stall),
        .perf_data_grant (perf_data_grant),
`endif
        .sram_rdata   (sram_rdata)
    );

    typedef struct {
        int          due;
        logic        chk;
        logic [31:0] rd;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [70:0] v;   // {inst_addr_ok, data_addr_ok, sram_en, sram_we, sram_addr, sram_wdata}
    } port_t;

    resp_t iq[$];
    resp_t dq[$];
    port_t pq[$];

    int          cyc;
    int          checks;
    int          failures;
    logic [31:0] pend_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // One stimulus cycle: drive inputs just after the edge, queue expectations.
    task automatic step(input logic rst_n, input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwr, input logic [3:0] strb,
                        input logic [31:0] daddr, input logic [31:0] dwdata,
                        input int g, input logic [31:0] resp_rd);
        port_t p;
        resp_t r;
        @(posedge clk);
        #1;
        reset      = rst_n;
        inst_req   = ireq;
        inst_addr  = iaddr;
        data_req   = dreq;
        data_wr    = dwr;
        data_wstrb = strb;
        data_addr  = daddr;
        data_wdata = dwdata;
        sram_rdata = pend_rd;
        pend_rd    = resp_rd;
        // A response due now is lost if reset is low this cycle.
        if (!rst_n) begin
            if (iq.size() > 0 && iq[$].due == cyc) void'(iq.pop_back());
            if (dq.size() > 0 && dq[$].due == cyc) void'(dq.pop_back());
        end
        p.cyc = cyc;
        case (g)
            GI:      p.v = {1'b1, 1'b0, 1'b1, 4'b0000, iaddr, 32'h0};
            GD:      p.v = {1'b0, 1'b1, 1'b1, (dwr ? strb : 4'b0000), daddr, dwdata};
            default: p.v = '0;
        endcase
        pq.push_back(p);
        r.due = cyc + 1;
        r.rd  = resp_rd;
        if (g == GI) begin
            r.chk = 1'b1;
            iq.push_back(r);
        end else if (g == GD) begin
            r.chk = !dwr;
            dq.push_back(r);
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, GN, 32'h0);
    endtask

    // Monitor: compares port state and routes responses against the queues.
    always @(negedge clk) begin
        port_t       p;
        resp_t       r;
        logic [70:0] act;
        logic        exp_i;
        logic        exp_d;
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            p   = pq.pop_front();
            act = {inst_addr_ok, data_addr_ok, sram_en, sram_we, sram_addr, sram_wdata};
            checks = checks + 1;
            if (act !== p.v) begin
                failures = failures + 1;
                $display("FAIL port cyc=%0d got=%h exp=%h", cyc, act, p.v);
            end
        end
        exp_i = (iq.size() > 0 && iq[0].due == cyc);
        checks = checks + 1;
        if (inst_data_ok !== exp_i) begin
            failures = failures + 1;
            $display("FAIL inst_data_ok cyc=%0d got=%b exp=%b", cyc, inst_data_ok, exp_i);
        end
        if (exp_i) begin
            r = iq.pop_front();
            if (r.chk && inst_data_ok === 1'b1) begin
                checks = checks + 1;
                if (inst_rdata !== r.rd) begin
                    failures = failures + 1;
                    $display("FAIL inst_rdata cyc=%0d got=%h exp=%h", cyc, inst_rdata, r.rd);
                end
            end
        end
        exp_d = (dq.size() > 0 && dq[0].due == cyc);
        checks = checks + 1;
        if (data_data_ok !== exp_d) begin
            failures = failures + 1;
            $display("FAIL data_data_ok cyc=%0d got=%b exp=%b", cyc, data_data_ok, exp_d);
        end
        if (exp_d) begin
            r = dq.pop_front();
            if (r.chk && data_data_ok === 1'b1) begin
                checks = checks + 1;
                if (data_rdata !== r.rd) begin
                    failures = failures + 1;
                    $display("FAIL data_rdata cyc=%0d got=%h exp=%h", cyc, data_rdata, r.rd);
                end
            end
        end
    end

    initial begin
        #100000;
        failures = failures + 1;
        $display("FAIL timeout cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
`ifdef MEM_ARB_PERF_CNT_EN
        logic [31:0] stall0;
        logic [31:0] dgnt0;
`endif
        cyc        = 0;
        checks     = 0;
        failures   = 0;
        pend_rd    = 32'h0;
        reset      = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        sram_rdata = 32'h0;

        // Reset held with both requests pending: everything quiet.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 32'h1C000000, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, GN, 32'h0);
        // Release: data wins first.
        step(1'b1, 1'b1, 32'h1C000000, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, GD, 32'h11111111);
        idle();

        // Instruction fetch alone.
        step(1'b1, 1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, GI, 32'h02C00000);
        idle();

        // Store then back-to-back load of the same word; load ignores strobe.
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABBCCDD, GD, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h100, 32'h0, GD, 32'h0000CCDD);
        idle();

`ifdef MEM_ARB_PERF_CNT_EN
        @(negedge clk);
        stall0 = perf_inst_stall;
        dgnt0  = perf_data_grant;
`endif
        // Both requests held for 10 cycles: D D D D I D D D D I.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 32'h1C000040, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0,
                 ((i == 4) || (i == 9)) ? GI : GD, 32'h50000000 + i);
        end
`ifdef MEM_ARB_PERF_CNT_EN
        @(negedge clk);
        checks = checks + 1;
        if (perf_inst_stall - stall0 !== 32'd8) begin
            failures = failures + 1;
            $display("FAIL perf_inst_stall got=%0d exp=8", perf_inst_stall - stall0);
        end
        checks = checks + 1;
        if (perf_data_grant - dgnt0 !== 32'd8) begin
            failures = failures + 1;
            $display("FAIL perf_data_grant got=%0d exp=8", perf_data_grant - dgnt0);
        end
`endif
        idle();

        // Inst grant, then reset lands while its response is due: dropped.
        step(1'b1, 1'b1, 32'h1C000080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, GI, 32'hDEADBEEF);
        step(1'b0, 1'b1, 32'h1C000080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, GN, 32'h0);
        idle();
        idle();
        idle();

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (iq.size() + dq.size() + pq.size() != 0) begin
            failures = failures + 1;
            $display("FAIL leftover got=%0d exp=0", iq.size() + dq.size() + pq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_port_arbiter
